// File: rtl/framebuffer_single_port_ctrl.sv
// framebuffer_single_port_ctrl: arbitrates one single-port RAM between the fragment pipeline, bulk clear and AXIS stream-out.
// Optional macro FB_CLEAR_ON_STREAM_EN adds a combined stream-then-clear operation.
module framebuffer_single_port_ctrl #(
   parameter int FRAMEBUFFER_INDEX_WIDTH = 14
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               pixelInPipeline,
   input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
   output logic [15:0]                        colorIn,
   input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
   input  logic                               colorWriteEnable,
   input  logic [15:0]                        colorOut,
   input  logic                               cmdValid,
   output logic                               cmdReady,
   input  logic                               cmdClear,
   input  logic                               cmdStream,
   input  logic [15:0]                        cmdClearColor,
   output logic                               collision,
   output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] memAddr,
   output logic [15:0]                        memWriteData,
   output logic                               memWriteEnable,
   input  logic [15:0]                        memReadData,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic                               m_axis_tlast,
   output logic [15:0]                        m_axis_tdata
);
   localparam int W = FRAMEBUFFER_INDEX_WIDTH;
   typedef enum logic [1:0] {
      IDLE, CLEAR, STREAM
`ifdef FB_CLEAR_ON_STREAM_EN
      , STREAM_CLEAR
`endif
   } state_t;
   state_t state, state_next;
   logic cmd_ready, accept, done, inflight, inflight_last;
   logic issue, step, space, pop, push, mem_we;
   logic [W-1:0] addr, mem_addr;
   logic [15:0] clear_color, mem_wdata;
   logic [1:0] count, c;
   logic [16:0] f0, f1;
`ifdef FB_CLEAR_ON_STREAM_EN
   logic ph;
`endif
   assign accept = cmdValid && cmd_ready;
   assign cmdReady = cmd_ready;
   assign m_axis_tvalid = count != 2'd0;
   assign m_axis_tdata = f0[15:0];
   assign m_axis_tlast = m_axis_tvalid && f0[16];
   assign pop = m_axis_tvalid && m_axis_tready;
   assign push = inflight;
   assign c = count - {1'b0, pop};
   // Read only when the FIFO can absorb it even if tready stays low from now on.
   assign space = (c + {1'b0, inflight}) < 2'd2;
   assign memAddr = reset ? mem_addr : '0;
   assign memWriteData = reset ? mem_wdata : '0;
   assign memWriteEnable = reset && mem_we;
   assign colorIn = reset ? memReadData : '0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (accept && cmdStream)
`ifdef FB_CLEAR_ON_STREAM_EN
               state_next = cmdClear ? STREAM_CLEAR : STREAM;
`else
               state_next = STREAM;
`endif
            else if (accept && cmdClear) state_next = CLEAR;
         CLEAR: if (&addr) state_next = IDLE;
         default: if (pop && f0[16]) state_next = IDLE;
      endcase
   end
   always_comb begin
      mem_addr = addr;
      mem_wdata = clear_color;
      mem_we = 1'b0;
      issue = 1'b0;
      step = 1'b0;
      case (state)
         IDLE: begin
            mem_addr = colorWriteEnable ? colorIndexWrite : colorIndexRead;
            mem_wdata = colorOut;
            mem_we = colorWriteEnable;
         end
         CLEAR: begin
            mem_we = 1'b1;
            step = 1'b1;
         end
         STREAM: begin
            issue = !done && space;
            step = issue;
         end
`ifdef FB_CLEAR_ON_STREAM_EN
         STREAM_CLEAR: begin
            issue = !ph && !done && space;
            mem_we = ph;
            step = ph;
         end
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready <= 1'b0;
         collision <= 1'b0;
         addr <= '0;
         done <= 1'b0;
         clear_color <= '0;
         inflight <= 1'b0;
         inflight_last <= 1'b0;
         count <= '0;
         f0 <= '0;
         f1 <= '0;
`ifdef FB_CLEAR_ON_STREAM_EN
         ph <= 1'b0;
`endif
      end else begin
         cmd_ready <= !accept && state_next == IDLE && !pixelInPipeline;
         inflight <= issue;
         inflight_last <= issue && &addr;
         count <= c + {1'b0, push};
         f0 <= (push && c == 2'd0) ? {inflight_last, memReadData} : (pop ? f1 : f0);
         f1 <= (push && c == 2'd1) ? {inflight_last, memReadData} : f1;
`ifdef FB_CLEAR_ON_STREAM_EN
         ph <= state == STREAM_CLEAR && issue;
`endif
         if (accept) begin
            addr <= '0;
            done <= 1'b0;
            clear_color <= cmdClearColor;
            collision <= 1'b0;
         end else begin
            // Every IDLE cycle implies a read, so any pipeline write displaces it.
            if (state == IDLE && colorWriteEnable) collision <= 1'b1;
            if (step) addr <= addr + W'(1);
            if (step && &addr) done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_framebuffer_single_port_ctrl.sv
// tb_framebuffer_single_port_ctrl: directed bench for framebuffer_single_port_ctrl at W=4 with a behavioural SPRAM.
module tb_framebuffer_single_port_ctrl;
   localparam int W = 4;
   localparam int N = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pixelInPipeline = 1'b0;
   logic [W-1:0] colorIndexRead = '0;
   logic [15:0] colorIn;
   logic [W-1:0] colorIndexWrite = '0;
   logic colorWriteEnable = 1'b0;
   logic [15:0] colorOut = '0;
   logic cmdValid = 1'b0;
   logic cmdReady;
   logic cmdClear = 1'b0;
   logic cmdStream = 1'b0;
   logic [15:0] cmdClearColor = '0;
   logic collision;
   logic [W-1:0] memAddr;
   logic [15:0] memWriteData;
   logic memWriteEnable;
   logic [15:0] memReadData;
   logic m_axis_tvalid;
   logic m_axis_tready = 1'b1;
   logic m_axis_tlast;
   logic [15:0] m_axis_tdata;
   logic [15:0] ram [N];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   framebuffer_single_port_ctrl #(.FRAMEBUFFER_INDEX_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .pixelInPipeline(pixelInPipeline),
      .colorIndexRead(colorIndexRead), .colorIn(colorIn),
      .colorIndexWrite(colorIndexWrite), .colorWriteEnable(colorWriteEnable), .colorOut(colorOut),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdClear(cmdClear), .cmdStream(cmdStream),
      .cmdClearColor(cmdClearColor), .collision(collision),
      .memAddr(memAddr), .memWriteData(memWriteData), .memWriteEnable(memWriteEnable),
      .memReadData(memReadData),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
   );

   always @(posedge clk) begin
      if (memWriteEnable) ram[memAddr] <= memWriteData;
      memReadData <= ram[memAddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_cmd(input logic clr, input logic str, input logic [15:0] col);
      int n = 0;
      @(posedge clk); #1;
      cmdValid = 1'b1;
      cmdClear = clr;
      cmdStream = str;
      cmdClearColor = col;
      while (!cmdReady && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("cmd_accept_in_time", 32'(n < 50), 1);
      @(posedge clk); #1;
      cmdValid = 1'b0;
      cmdClear = 1'b0;
      cmdStream = 1'b0;
   endtask

   task automatic collect(input string tag, input int budget);
      int idx = 0;
      int cyc = 0;
      int first = 0;
      int last = 0;
      logic held = 1'b0;
      logic [16:0] hd = '0;
      while (idx < N && cyc < budget) begin
         @(negedge clk);
         if (held) begin
            check({tag, "_hold_valid"}, m_axis_tvalid, 1);
            check({tag, "_hold_beat"}, {m_axis_tlast, m_axis_tdata}, hd);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check({tag, "_data"}, m_axis_tdata, 16'hA000 | 16'(idx));
            check({tag, "_last"}, m_axis_tlast, 32'(idx == N - 1));
            if (idx == 0) first = cyc;
            last = cyc;
            idx++;
         end
         held = m_axis_tvalid && !m_axis_tready;
         hd = {m_axis_tlast, m_axis_tdata};
         @(posedge clk); #1;
         cyc++;
         if (tag == "s2") m_axis_tready = 1'($urandom_range(0, 1));
      end
      check({tag, "_beats"}, idx, N);
      if (tag == "s1") check("s1_span", last - first, N - 1);
      m_axis_tready = 1'b1;
      check({tag, "_valid_after"}, m_axis_tvalid, 0);
      check({tag, "_last_after"}, m_axis_tlast, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", cmdReady, 0);
      check("rst_collision", collision, 0);
      check("rst_we", memWriteEnable, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_addr", memAddr, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", cmdReady, 1);

      // reset mid-clear
      do_cmd(1'b1, 1'b0, 16'hAAAA);
      repeat (5) @(posedge clk);
      #1;
      check("midclr_addr", memAddr, 5);
      check("midclr_we", memWriteEnable, 1);
      reset = 1'b0;
      #1;
      check("midclr_rst_we", memWriteEnable, 0);
      check("midclr_rst_ready", cmdReady, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midclr_idle_we", memWriteEnable, 0);
      check("midclr_ready", cmdReady, 1);

      // full clear
      do_cmd(1'b1, 1'b0, 16'hF81F);
      check("clr_ready_drop", cmdReady, 0);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         check("clr_addr", memAddr, i);
         check("clr_we", memWriteEnable, 1);
         check("clr_data", memWriteData, 16'hF81F);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("clr_done_we", memWriteEnable, 0);
      check("clr_done_ready", cmdReady, 1);
      colorIndexRead = 4'd9;
      @(posedge clk); #1;
      @(negedge clk);
      check("clr_readback9", colorIn, 16'hF81F);

      // pipeline write, read-back and collision
      check("pre_collision", collision, 0);
      @(posedge clk); #1;
      colorWriteEnable = 1'b1;
      colorIndexWrite = 4'd3;
      colorOut = 16'h1234;
      colorIndexRead = 4'd7;
      @(negedge clk);
      check("wr_addr", memAddr, 3);
      check("wr_we", memWriteEnable, 1);
      check("wr_data", memWriteData, 16'h1234);
      @(posedge clk); #1;
      colorWriteEnable = 1'b0;
      colorIndexRead = 4'd3;
      @(negedge clk);
      check("rd_addr", memAddr, 3);
      check("collision_set", collision, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rd_data", colorIn, 16'h1234);

      // address pattern
      for (int a = 0; a < N; a++) begin
         @(posedge clk); #1;
         colorWriteEnable = 1'b1;
         colorIndexWrite = 4'(a);
         colorOut = 16'hA000 | 16'(a);
      end
      @(posedge clk); #1;
      colorWriteEnable = 1'b0;

      // stream at full rate, then with random back-pressure
      do_cmd(1'b0, 1'b1, 16'h0000);
      check("collision_cleared", collision, 0);
      check("s1_ready_drop", cmdReady, 0);
      collect("s1", 100);
      check("s1_ready_after", cmdReady, 1);
      do_cmd(1'b0, 1'b1, 16'h0000);
      m_axis_tready = 1'($urandom_range(0, 1));
      collect("s2", 400);

      // command held off while the pipeline is busy
      @(posedge clk); #1;
      pixelInPipeline = 1'b1;
      @(posedge clk); #1;
      cmdValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("busy_ready", cmdReady, 0);
         @(posedge clk); #1;
      end
      pixelInPipeline = 1'b0;
      @(posedge clk); #1;
      check("drain_ready", cmdReady, 1);
      @(posedge clk); #1;
      check("noop_ready_drop", cmdReady, 0);
      cmdValid = 1'b0;
      @(posedge clk); #1;
      check("noop_ready_back", cmdReady, 1);
      check("noop_idle_tvalid", m_axis_tvalid, 0);

      // stream with clear flag set
      do_cmd(1'b1, 1'b1, 16'h0000);
      collect("s3", 200);
      check("s3_ready_after", cmdReady, 1);
      colorIndexRead = '0;
      for (int a = 0; a < N; a++) begin
         @(posedge clk); #1;
`ifdef FB_CLEAR_ON_STREAM_EN
         check("s3_ram", colorIn, 16'h0000);
`else
         check("s3_ram", colorIn, 16'hA000 | 16'(a));
`endif
         colorIndexRead = 4'(a + 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
